sdf_ntt_stage: RTL and testbench
================================

Name: sdf_ntt_stage

Overview:
- Parametrised radix-2 single-path delay-feedback (SDF) NTT stage.
- Generalises the single-shot 8-point datapath to:
  - any power-of-two delay depth;
  - a real per-sample twiddle table;
  - valid-qualified streaming;
  - back-to-back blocks and an explicit drain.
- Stages chain output-to-input to build an N-point pipelined NTT (decimation-in-frequency).
- One block = 2·DELAY consecutive valid samples.

Parameters:
- W, 32, data word width; all operands are residues < MODULUS.
- MODULUS, 7681, prime modulus q; requires MODULUS < 2^(W-1).
- DELAY, 4, feedback delay depth (power of two, ≥2). Also the twiddle table depth.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_data valid this cycle.
- in_data  in  W  input residue.
- drain  in  1  flush request; acts as a zero-valued input while draining.
- tw_we  in  1  twiddle table write enable.
- tw_addr  in  $clog2(DELAY)  twiddle write address.
- tw_wdata  in  W  twiddle value (residue).
- out_valid  out  1  out_data valid (registered).
- out_data  out  W  output residue (registered).
- primed  out  1  delay line holds pending differences awaiting output.

Behaviour:
- State:
  - cnt: $clog2(2·DELAY) bits; phase = cnt MSB; idx = cnt low bits.
  - dl: DELAY-word shift register; head = oldest word.
  - tw[0..DELAY-1]: twiddle table.
  - primed flag.
- Reset (sync, clk edge with rst=1), all outputs 0:
  - out_valid=0, out_data=0, cnt=0, primed=0, all dl words=0, all tw entries=1.
  - Reset mid-block discards all pending data.
- Advance event:
  - adv = in_valid, OR (drain AND primed AND phase==0).
  - Sample x = in_data if in_valid, else 0. in_valid has priority over drain.
  - No adv: nothing changes except twiddle writes; out_valid=0 next cycle.
- Phase 0 (cnt < DELAY), on adv:
  - Push x into dl, pop head h.
  - out_data <= (h·tw[idx]) mod MODULUS; out_valid <= primed.
- Phase 1 (cnt ≥ DELAY), on adv (in_valid only):
  - a = head, b = x.
  - out_data <= (a+b) mod q; out_valid <= 1.
  - Push (a−b) mod q into dl.
  - primed <= 1 on the adv where cnt == 2·DELAY−1.
- cnt:
  - Increments on each adv and wraps 2·DELAY−1 → 0.
  - Drain-only adv with cnt == DELAY−1: cnt <= 0 and primed <= 0. The stage returns to idle-block-start, not phase 1.
- Drain:
  - Ignored (no adv) when primed=0 or phase==1.
  - Remains valid to hold continuously; it self-terminates after DELAY outputs.
- Arithmetic:
  - add: s=a+b (W+1 bits); subtract q if s ≥ q.
  - sub: a ≥ b ? a−b : a−b+q.
  - mul: full 2W-bit product reduced mod q, combinational into the out_data register.
  - Exact result required; the reduction method is free.
- Latency: out_data/out_valid appear exactly 1 cycle after the adv that produces them. The stage's sample delay is DELAY valid samples.
- Twiddle table:
  - Synchronous write.
  - Combinational read at idx.
  - Write and read of the same address in one cycle: the read returns the old value.
  - Writes are permitted at any time, including during streaming.
- in_valid gaps may occur anywhere. Output ordering and values are independent of gap pattern.

Test Plan:
- Reset, then DELAY=4, tw=1, in_valid inputs 1..8 contiguous:
  - out_valid=0 for inputs 1–4;
  - then outputs 6, 8, 10, 12;
  - primed=1.
- Continue from previous with drain=1 for 5 cycles:
  - outputs 7677 ×4;
  - 5th cycle out_valid=0;
  - primed=0, cnt=0.
- Load tw = {1,2,3,4} via tw_we, repeat inputs 1..8 then drain:
  - drain outputs 7677, 7673, 7669, 7665.
- Back-to-back blocks 1..8 then 9..16 (tw=1):
  - second block phase-0 outputs 7677 ×4 (interleaved correctly);
  - then 22, 24, 26, 28.
- Random in_valid gaps and drain asserted during phase 1 or simultaneously with in_valid:
  - output stream identical to the gap-free golden model;
  - drain has no effect in those cycles.
- Modular boundaries with inputs 7680 and 1 as (a, b):
  - sum = 0, difference = 7679.
- Mid-stream reset:
  - all outputs 0 next cycle;
  - a new block behaves as in the first scenario.

Source files
------------

// File: rtl/sdf_ntt_stage.sv
// Radix-2 single-path delay-feedback NTT stage (decimation-in-frequency).
// Latency: out_valid/out_data are registered, one cycle after the advancing sample; sample delay is DELAY.
// Backpressure: none; in_valid gaps stall the stage, and drain pushes zeros until pending differences are flushed.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid, in_data            input residue stream
//   drain                        flush request (zero-valued input while primed and in phase 0)
//   tw_we, tw_addr, tw_wdata     twiddle table write port
//   out_valid, out_data          registered output residue stream
//   primed                       delay line holds differences not yet emitted
module sdf_ntt_stage #(
    parameter int W       = 32,
    parameter int MODULUS = 7681,
    parameter int DELAY   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    input  logic                     drain,
    input  logic                     tw_we,
    input  logic [$clog2(DELAY)-1:0] tw_addr,
    input  logic [W-1:0]             tw_wdata,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic                     primed
);

    localparam int CW = $clog2(2 * DELAY);
    localparam int AW = $clog2(DELAY);

    localparam logic [W-1:0]    Q        = W'(MODULUS);
    localparam logic [W:0]      Q_EXT    = (W + 1)'(MODULUS);
    localparam logic [2*W-1:0]  Q_WIDE   = (2 * W)'(MODULUS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0]   CNT_MID  = CW'(DELAY - 1);

    logic [W-1:0]  dl [DELAY];
    logic [W-1:0]  tw [DELAY];
    logic [CW-1:0] cnt;

    logic          phase;
    logic [AW-1:0] idx;
    logic          adv;
    logic [W-1:0]  x;
    logic [W-1:0]  head;
    logic [W:0]    sum_w;
    logic [W-1:0]  sum_res;
    logic [W-1:0]  diff_res;
    logic [2*W-1:0] prod;
    logic [W-1:0]  mul_res;
    logic [W-1:0]  push_val;

    assign phase = cnt[CW-1];
    assign idx   = cnt[AW-1:0];
    assign head  = dl[0];

    // in_valid wins over drain; drain only injects zeros while pending
    // differences exist and the stage is in the pass-through half.
    assign adv = in_valid | (drain & primed & ~phase);
    assign x   = in_valid ? in_data : '0;

    always_comb begin
        sum_w   = {1'b0, head} + {1'b0, x};
        sum_res = (sum_w >= Q_EXT) ? W'(sum_w - Q_EXT) : W'(sum_w);
    end

    // Operands are residues, so a single conditional add of q suffices;
    // the W-bit wraparound of head - x cancels when q is added back.
    assign diff_res = (head >= x) ? (head - x) : (head - x + Q);

    assign prod    = {{W{1'b0}}, head} * {{W{1'b0}}, tw[idx]};
    assign mul_res = W'(prod % Q_WIDE);

    // Phase 0 fills the line with raw samples; phase 1 replaces them with differences.
    assign push_val = phase ? diff_res : x;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
            primed    <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                dl[i] <= '0;
                tw[i] <= W'(1);
            end
        end else begin
            out_valid <= 1'b0;

            // Read side sees the old entry in the cycle of a write.
            if (tw_we) begin
                tw[tw_addr] <= tw_wdata;
            end

            if (adv) begin
                for (int i = 0; i < DELAY - 1; i++) begin
                    dl[i] <= dl[i+1];
                end
                dl[DELAY-1] <= push_val;

                out_valid <= phase ? 1'b1 : primed;
                out_data  <= phase ? sum_res : mul_res;

                if (!in_valid && cnt == CNT_MID) begin
                    // Last flushed difference: back to idle block start, not phase 1.
                    cnt    <= '0;
                    primed <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        primed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sdf_ntt_stage.sv
// Bench for sdf_ntt_stage: directed sequence with an in-order scoreboard of expected outputs.
// Latency: every step drives one cycle and checks the registered outputs 1 time unit after the edge.
// Backpressure: none; idle cycles model in_valid gaps.
module tb_sdf_ntt_stage;

    localparam int W = 32;
    localparam int Q = 7681;
    localparam int D = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic [W-1:0]         in_data = '0;
    logic                 drain = 1'b0;
    logic                 tw_we = 1'b0;
    logic [$clog2(D)-1:0] tw_addr = '0;
    logic [W-1:0]         tw_wdata = '0;
    logic                 out_valid;
    logic [W-1:0]         out_data;
    logic                 primed;

    int checks = 0;
    int fails  = 0;

    logic [W-1:0] exp_q [$];

    sdf_ntt_stage #(.W(W), .MODULUS(Q), .DELAY(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .drain(drain),
        .tw_we(tw_we), .tw_addr(tw_addr), .tw_wdata(tw_wdata),
        .out_valid(out_valid), .out_data(out_data), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        checks++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic chk_empty(input string tag);
        checks++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s: observed %0d outputs still owed, expected 0", tag, exp_q.size());
        end
    endtask

    // One clock of stimulus; any valid output is matched against the scoreboard head.
    task automatic step(input logic v, input logic [W-1:0] d, input logic dr);
        logic [W-1:0] e;
        in_valid = v;
        in_data  = d;
        drain    = dr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        drain    = 1'b0;
        if (out_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_valid: observed out_valid=1 data=%0d expected out_valid=0", out_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
            end
        end
    endtask

    task automatic tw_write(input int a, input logic [W-1:0] v);
        tw_we    = 1'b1;
        tw_addr  = a[$clog2(D)-1:0];
        tw_wdata = v;
        @(posedge clk);
        #1;
        tw_we = 1'b0;
    endtask

    task automatic feed_range(input int first, input int last);
        for (int k = first; k <= last; k++) step(1'b1, W'(k), 1'b0);
    endtask

    task automatic drain_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1);
    endtask

    task automatic push4(input int a, input int b, input int c, input int d4);
        exp_q.push_back(W'(a));
        exp_q.push_back(W'(b));
        exp_q.push_back(W'(c));
        exp_q.push_back(W'(d4));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = W'(99);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    logic [W-1:0] blk  [2*D];
    logic [W-1:0] pend [D];
    logic [W-1:0] twv  [D];
    bit           have_pend;
    longint unsigned t;

    initial begin
        // Reset state
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_primed", W'(primed), W'(0));

        // First block, unit twiddles: no output for 1..4, then pairwise sums
        push4(6, 8, 10, 12);
        feed_range(1, 4);
        chk("no_early_valid", W'(exp_q.size()), W'(4));
        feed_range(5, 8);
        chk_empty("blk1");
        chk("primed_after_blk1", W'(primed), W'(1));

        // Drain: four flushed differences (1-5 mod q), fifth cycle idle
        push4(7677, 7677, 7677, 7677);
        drain_cycles(4);
        chk("primed_after_drain", W'(primed), W'(0));
        step(1'b0, '0, 1'b1);
        chk("drain_5th_invalid", W'(out_valid), W'(0));
        chk_empty("drain1");

        // Non-unit twiddles scale the flushed differences
        tw_write(0, 1); tw_write(1, 2); tw_write(2, 3); tw_write(3, 4);
        push4(6, 8, 10, 12);
        feed_range(1, 8);
        push4(7677, 7673, 7669, 7665);
        drain_cycles(5);
        chk_empty("tw_scaled");
        for (int i = 0; i < D; i++) tw_write(i, 1);

        // Back-to-back blocks
        push4(6, 8, 10, 12);
        push4(7677, 7677, 7677, 7677);
        push4(22, 24, 26, 28);
        feed_range(1, 16);
        push4(7677, 7677, 7677, 7677);
        drain_cycles(5);
        chk_empty("back_to_back");

        // Modular boundaries: 7680+1 wraps to 0, 7680-1 = 7679; 7679*7680 = (-2)(-1) = 2
        push4(0, 0, 0, 0);
        for (int k = 0; k < D; k++) step(1'b1, W'(7680), 1'b0);
        for (int k = 0; k < D; k++) step(1'b1, W'(1), 1'b0);
        tw_write(0, W'(7680));
        push4(2, 7679, 7679, 7679);
        drain_cycles(5);
        chk_empty("boundaries");

        // Random gaps, random twiddles, drain only where it must be ignored
        for (int i = 0; i < D; i++) begin
            twv[i] = W'($urandom_range(Q - 1, 0));
            tw_write(i, twv[i]);
        end
        have_pend = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 2 * D; k++) blk[k] = W'($urandom_range(Q - 1, 0));
            if (have_pend) begin
                for (int i = 0; i < D; i++) begin
                    t = (longint'(pend[i]) * longint'(twv[i])) % Q;
                    exp_q.push_back(W'(t));
                end
            end
            for (int i = 0; i < D; i++) begin
                t = (longint'(blk[i]) + longint'(blk[i+D])) % Q;
                exp_q.push_back(W'(t));
                t = (longint'(blk[i]) + Q - longint'(blk[i+D])) % Q;
                pend[i] = W'(t);
            end
            have_pend = 1'b1;
            for (int k = 0; k < 2 * D; k++) begin
                int g;
                g = $urandom_range(2, 0);
                for (int j = 0; j < g; j++)
                    step(1'b0, '0, (k >= D) ? 1'($urandom_range(1, 0)) : 1'b0);
                step(1'b1, blk[k], 1'($urandom_range(1, 0)));
            end
        end
        for (int i = 0; i < D; i++) begin
            t = (longint'(pend[i]) * longint'(twv[i])) % Q;
            exp_q.push_back(W'(t));
        end
        drain_cycles(5);
        chk_empty("random_gaps");
        chk("primed_after_random", W'(primed), W'(0));

        // Mid-stream reset discards pending data and restores unit twiddles
        exp_q.push_back(W'(6));
        exp_q.push_back(W'(8));
        feed_range(1, 6);
        chk_empty("pre_reset");
        do_reset();
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_out_data", out_data, W'(0));
        chk("mid_rst_primed", W'(primed), W'(0));
        push4(6, 8, 10, 12);
        feed_range(1, 8);
        chk("primed_post_reset", W'(primed), W'(1));
        push4(7677, 7677, 7677, 7677);
        drain_cycles(5);
        chk_empty("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
